// File: rtl/pc_seq_pkg.sv
// Purpose: shared types and select codes for the PC fetch sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: fetch FSM state enum and the 2-bit next-PC select codes reported on pc_sel_o.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2
  } state_e;

  localparam logic [1:0] SEL_SEQ  = 2'b00;
  localparam logic [1:0] SEL_BR   = 2'b01;
  localparam logic [1:0] SEL_JMP  = 2'b10;
  localparam logic [1:0] SEL_TRAP = 2'b11;

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// Purpose: instruction-memory fetch port (req/ack handshake plus address).
// Latency: n/a (wires only).
// Backpressure: the master holds imem_req_o until the slave returns imem_ack_i.
// Ports: master drives imem_req_o/imem_addr_o and samples imem_ack_i; slave is the mirror.
interface pc_fetch_sequencer_if #(
  parameter int PC_W = 12
);
  logic            imem_req_o;
  logic [PC_W-1:0] imem_addr_o;
  logic            imem_ack_i;

  modport master (output imem_req_o, output imem_addr_o, input imem_ack_i);
  modport slave  (input imem_req_o, input imem_addr_o, output imem_ack_i);
endinterface

// File: rtl/pc_next_sel.sv
// Purpose: combinational next-PC priority select (jump > branch > sequential).
// Latency: 0 cycles, pure combinational.
// Backpressure: none; the caller decides when the result is consumed.
// Ports: current PC, jump/branch strobes+targets, pending redirect entry -> next PC, select code, misalign flag.
// Option: PC_MISALIGN_TRAP_EN turns misaligned redirect targets into a trap to TRAP_PC.
module pc_next_sel
  import pc_seq_pkg::*;
#(
  parameter int              PC_W    = 12,
  parameter logic [PC_W-1:0] TRAP_PC = PC_W'(12'hFF0)
) (
  input  logic [PC_W-1:0] pc_i,
  input  logic            jump_i,
  input  logic [PC_W-1:0] jump_target_i,
  input  logic            branch_taken_i,
  input  logic [PC_W-1:0] branch_target_i,
  input  logic            pend_vld_i,
  input  logic            pend_jmp_i,
  input  logic [PC_W-1:0] pend_tgt_i,
  output logic [PC_W-1:0] next_pc_o,
  output logic [1:0]      sel_o,
  output logic            misalign_o
);

  logic [PC_W-1:0] tgt;
  logic            redirect;

  always_comb begin
    tgt        = '0;
    redirect   = 1'b0;
    sel_o      = SEL_SEQ;
    misalign_o = 1'b0;
    // Sequential candidate wraps modulo 2^PC_W.
    next_pc_o  = pc_i + PC_W'(4);

    // A live strobe is newer than a pending entry of the same kind.
    if (jump_i) begin
      redirect = 1'b1; tgt = jump_target_i;   sel_o = SEL_JMP;
    end else if (pend_vld_i && pend_jmp_i) begin
      redirect = 1'b1; tgt = pend_tgt_i;      sel_o = SEL_JMP;
    end else if (branch_taken_i) begin
      redirect = 1'b1; tgt = branch_target_i; sel_o = SEL_BR;
    end else if (pend_vld_i) begin
      redirect = 1'b1; tgt = pend_tgt_i;      sel_o = SEL_BR;
    end

    if (redirect) begin
`ifdef PC_MISALIGN_TRAP_EN
      if (tgt[1:0] != 2'b00) begin
        next_pc_o  = TRAP_PC;
        sel_o      = SEL_TRAP;
        misalign_o = 1'b1;
      end else begin
        next_pc_o = tgt;
      end
`else
      next_pc_o = {tgt[PC_W-1:2], 2'b00};
`endif
    end
  end

`ifndef PC_MISALIGN_TRAP_EN
  // Trap address and target low bits only matter when the trap option is built in.
  logic unused_trap_bits;
  assign unused_trap_bits = ^{TRAP_PC, tgt[1:0]};
`endif

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Purpose: owns the program counter, latches redirects and runs the imem req/ack fetch handshake.
// Latency: pc_o/pc_sel_o/instr_valid_o update one cycle after an accepted ack; zero-wait memory sustains one fetch per cycle.
// Backpressure: stall_i suppresses a new request; once issued, the request is held until imem_ack_i.
// Ports: clk, rst_n (async active-low), stall_i, branch/jump strobes+targets, imem (master fetch port),
//        pc_o, pc_sel_o, instr_valid_o, misalign_o. Option macro: PC_MISALIGN_TRAP_EN.
module pc_fetch_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              PC_W     = 12,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [PC_W-1:0] TRAP_PC  = PC_W'(12'hFF0)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        stall_i,
  input  logic                        branch_taken_i,
  input  logic [PC_W-1:0]             branch_target_i,
  input  logic                        jump_i,
  input  logic [PC_W-1:0]             jump_target_i,
  pc_fetch_sequencer_if.master        imem,
  output logic [PC_W-1:0]             pc_o,
  output logic [1:0]                  pc_sel_o,
  output logic                        instr_valid_o,
  output logic                        misalign_o
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [1:0]      sel_q, sel_d;
  logic            instr_valid_q, instr_valid_d;
  logic            misalign_q, misalign_d;
  logic            pend_vld_q, pend_vld_d;
  logic            pend_jmp_q, pend_jmp_d;
  logic [PC_W-1:0] pend_tgt_q, pend_tgt_d;

  logic            req_c;
  logic            accept_c;
  logic [PC_W-1:0] next_pc_c;
  logic [1:0]      next_sel_c;
  logic            next_mis_c;

  pc_next_sel #(
    .PC_W    (PC_W),
    .TRAP_PC (TRAP_PC)
  ) u_next_sel (
    .pc_i            (pc_q),
    .jump_i          (jump_i),
    .jump_target_i   (jump_target_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .pend_vld_i      (pend_vld_q),
    .pend_jmp_i      (pend_jmp_q),
    .pend_tgt_i      (pend_tgt_q),
    .next_pc_o       (next_pc_c),
    .sel_o           (next_sel_c),
    .misalign_o      (next_mis_c)
  );

  // In WAIT the request is already committed, so stall_i no longer gates it.
  assign req_c    = (state_q == WAIT) || ((state_q == FETCH) && !stall_i);
  assign accept_c = req_c && imem.imem_ack_i;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    sel_d         = sel_q;
    pend_vld_d    = pend_vld_q;
    pend_jmp_d    = pend_jmp_q;
    pend_tgt_d    = pend_tgt_q;
    instr_valid_d = accept_c;
    misalign_d    = accept_c && next_mis_c;

    unique case (state_q)
      BOOT:    state_d = FETCH;
      FETCH:   if (req_c && !imem.imem_ack_i) state_d = WAIT;
      WAIT:    if (imem.imem_ack_i) state_d = FETCH;
      default: state_d = BOOT;
    endcase

    if (accept_c) begin
      // Strobes in this cycle are consumed directly; any pending entry is spent.
      pc_d       = next_pc_c;
      sel_d      = next_sel_c;
      pend_vld_d = 1'b0;
    end else if (jump_i) begin
      // A jump overwrites whatever is pending; a same-cycle branch is dropped.
      pend_vld_d = 1'b1;
      pend_jmp_d = 1'b1;
      pend_tgt_d = jump_target_i;
    end else if (branch_taken_i && !(pend_vld_q && pend_jmp_q)) begin
      pend_vld_d = 1'b1;
      pend_jmp_d = 1'b0;
      pend_tgt_d = branch_target_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      sel_q         <= SEL_SEQ;
      instr_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
      pend_vld_q    <= 1'b0;
      pend_jmp_q    <= 1'b0;
      pend_tgt_q    <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      sel_q         <= sel_d;
      instr_valid_q <= instr_valid_d;
      misalign_q    <= misalign_d;
      pend_vld_q    <= pend_vld_d;
      pend_jmp_q    <= pend_jmp_d;
      pend_tgt_q    <= pend_tgt_d;
    end
  end

  assign imem.imem_req_o  = req_c;
  assign imem.imem_addr_o = pc_q;
  assign pc_o             = pc_q;
  assign pc_sel_o         = sel_q;
  assign instr_valid_o    = instr_valid_q;
  assign misalign_o       = misalign_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Purpose: self-checking bench for pc_fetch_sequencer (directed scenarios then random traffic).
// Latency: n/a.
// Backpressure: n/a. Honours PC_MISALIGN_TRAP_EN the same way as the design.
module tb_pc_fetch_sequencer;
  import pc_seq_pkg::*;

  localparam logic [11:0] RESET_PC = 12'h000;
  localparam logic [11:0] TRAP_PC  = 12'hFF0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_i = 1'b0;
  logic        branch_taken_i = 1'b0;
  logic [11:0] branch_target_i = '0;
  logic        jump_i = 1'b0;
  logic [11:0] jump_target_i = '0;
  logic        ack = 1'b0;
  logic [11:0] pc_o;
  logic [1:0]  pc_sel_o;
  logic        instr_valid_o;
  logic        misalign_o;

  pc_fetch_sequencer_if #(.PC_W(12)) imem ();
  assign imem.imem_ack_i = ack;

  pc_fetch_sequencer #(.PC_W(12), .RESET_PC(RESET_PC), .TRAP_PC(TRAP_PC)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall_i         (stall_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .jump_i          (jump_i),
    .jump_target_i   (jump_target_i),
    .imem            (imem),
    .pc_o            (pc_o),
    .pc_sel_o        (pc_sel_o),
    .instr_valid_o   (instr_valid_o),
    .misalign_o      (misalign_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: architectural PC, last select, pulses, fetch phase and pending redirect.
  logic [11:0] m_pc;
  logic [1:0]  m_sel;
  logic        m_valid, m_mis;
  int          m_phase;     // 0 = just out of reset, 1 = free to request, 2 = request outstanding
  int          m_pend;      // 0 = none, 1 = branch, 2 = jump
  logic [11:0] m_pend_tgt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_sel = 2'b00; m_valid = 1'b0; m_mis = 1'b0;
    m_phase = 0; m_pend = 0; m_pend_tgt = '0;
  endtask

  task automatic drive(input bit st, input bit ak, input bit br, input logic [11:0] bt,
                       input bit jp, input logic [11:0] jt);
    stall_i = st; ack = ak; branch_taken_i = br; branch_target_i = bt;
    jump_i = jp; jump_target_i = jt;
  endtask

  // One clock: check the request before the edge, advance the model, check registered outputs after.
  task automatic step(input string tag);
    bit          req, acc, redir;
    logic [11:0] tgt;
    logic [1:0]  sel;
    #1;
    req = (m_phase == 2) || (m_phase == 1 && !stall_i);
    chk({tag, "/req"}, {31'd0, imem.imem_req_o}, {31'd0, req});
    acc = req && ack;
    m_valid = acc;
    m_mis = 1'b0;
    if (acc) begin
      redir = 1'b1; tgt = '0; sel = 2'b00;
      if (jump_i)                  begin tgt = jump_target_i;   sel = 2'b10; end
      else if (m_pend == 2)        begin tgt = m_pend_tgt;      sel = 2'b10; end
      else if (branch_taken_i)     begin tgt = branch_target_i; sel = 2'b01; end
      else if (m_pend == 1)        begin tgt = m_pend_tgt;      sel = 2'b01; end
      else redir = 1'b0;
      if (!redir) begin
        m_pc = m_pc + 12'd4;
        m_sel = 2'b00;
      end else begin
`ifdef PC_MISALIGN_TRAP_EN
        if (tgt % 4 != 0) begin m_pc = TRAP_PC; m_sel = 2'b11; m_mis = 1'b1; end
        else begin m_pc = tgt; m_sel = sel; end
`else
        m_pc = tgt - (tgt % 4);
        m_sel = sel;
`endif
      end
      m_pend = 0;
    end else if (jump_i) begin
      m_pend = 2; m_pend_tgt = jump_target_i;
    end else if (branch_taken_i && m_pend != 2) begin
      m_pend = 1; m_pend_tgt = branch_target_i;
    end
    case (m_phase)
      0: m_phase = 1;
      1: if (req && !ack) m_phase = 2;
      default: if (ack) m_phase = 1;
    endcase
    @(posedge clk);
    #1;
    chk({tag, "/pc"},    {20'd0, pc_o},             {20'd0, m_pc});
    chk({tag, "/addr"},  {20'd0, imem.imem_addr_o}, {20'd0, m_pc});
    chk({tag, "/sel"},   {30'd0, pc_sel_o},         {30'd0, m_sel});
    chk({tag, "/valid"}, {31'd0, instr_valid_o},    {31'd0, m_valid});
    chk({tag, "/mis"},   {31'd0, misalign_o},       {31'd0, m_mis});
  endtask

  initial begin
    model_reset();
    drive(0, 0, 0, '0, 0, '0);
    repeat (2) @(posedge clk);
    #1;
    // Reset state.
    chk("rst/pc",    {20'd0, pc_o}, {20'd0, RESET_PC});
    chk("rst/addr",  {20'd0, imem.imem_addr_o}, {20'd0, RESET_PC});
    chk("rst/req",   {31'd0, imem.imem_req_o}, 32'd0);
    chk("rst/sel",   {30'd0, pc_sel_o}, 32'd0);
    chk("rst/valid", {31'd0, instr_valid_o}, 32'd0);
    chk("rst/mis",   {31'd0, misalign_o}, 32'd0);
    rst_n = 1'b1;

    // Zero-wait memory straight out of reset: 000, 004, 008 with continuous valid.
    drive(0, 1, 0, '0, 0, '0);
    step("boot");
    chk("boot/pc0", {20'd0, pc_o}, 32'h000);
    step("zw1");
    chk("zw1/pc4", {20'd0, pc_o}, 32'h004);
    step("zw2");
    chk("zw2/pc8", {20'd0, pc_o}, 32'h008);
    chk("zw2/valid", {31'd0, instr_valid_o}, 32'd1);

    // Simultaneous jump and branch on an accepted ack: jump wins.
    drive(0, 1, 1, 12'h100, 1, 12'h200);
    step("jb");
    chk("jb/pc", {20'd0, pc_o}, 32'h200);
    chk("jb/sel", {30'd0, pc_sel_o}, 32'h2);

    // Branch strobed while waiting, acked three cycles later.
    drive(0, 0, 0, '0, 0, '0);
    step("w0");
    drive(0, 0, 1, 12'h040, 0, '0);
    step("w1");
    drive(0, 0, 0, '0, 0, '0);
    step("w2");
    step("w3");
    drive(0, 1, 0, '0, 0, '0);
    step("w4");
    chk("w4/pc", {20'd0, pc_o}, 32'h040);
    chk("w4/sel", {30'd0, pc_sel_o}, 32'h1);
    step("w5");
    chk("w5/pc_seq", {20'd0, pc_o}, 32'h044);
    chk("w5/sel", {30'd0, pc_sel_o}, 32'h0);

    // Stall in FETCH with ack held high: nothing moves.
    drive(1, 1, 0, '0, 0, '0);
    for (int i = 0; i < 4; i++) step("stall");
    chk("stall/pc", {20'd0, pc_o}, 32'h044);
    chk("stall/valid", {31'd0, instr_valid_o}, 32'd0);

    // Wrap from 0xFFC.
    drive(0, 1, 0, '0, 1, 12'hFFC);
    step("wrapj");
    drive(0, 1, 0, '0, 0, '0);
    step("wrap");
    chk("wrap/pc", {20'd0, pc_o}, 32'h000);
    chk("wrap/sel", {30'd0, pc_sel_o}, 32'h0);

    // Misaligned jump target.
    drive(0, 1, 0, '0, 1, 12'h102);
    step("mis");
`ifdef PC_MISALIGN_TRAP_EN
    chk("mis/pc", {20'd0, pc_o}, {20'd0, TRAP_PC});
    chk("mis/sel", {30'd0, pc_sel_o}, 32'h3);
    chk("mis/pulse", {31'd0, misalign_o}, 32'd1);
`else
    chk("mis/pc", {20'd0, pc_o}, 32'h100);
    chk("mis/pulse", {31'd0, misalign_o}, 32'd0);
`endif
    drive(0, 1, 0, '0, 0, '0);
    step("mis_after");
    chk("mis_after/pulse", {31'd0, misalign_o}, 32'd0);

    // Reset asserted mid-WAIT with a pending jump: request drops at once, pending is discarded.
    drive(0, 0, 0, '0, 0, '0);
    step("rw0");
    drive(0, 0, 0, '0, 1, 12'h300);
    step("rw1");
    #2 rst_n = 1'b0;
    #1;
    chk("rw/req", {31'd0, imem.imem_req_o}, 32'd0);
    chk("rw/pc",  {20'd0, pc_o}, {20'd0, RESET_PC});
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    drive(0, 1, 0, '0, 0, '0);
    step("rw_boot");
    step("rw_fetch");
    chk("rw/pend_gone", {20'd0, pc_o}, 32'h004);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 9) < 6,
            $urandom_range(0, 6) == 0, 12'($urandom),
            $urandom_range(0, 9) == 0, 12'($urandom));
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
